// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage between the PC unit and decode.
// Issues word-aligned imem requests, pairs in-order responses with their PCs
// through a tag queue, and buffers {pc, instr} pairs in a FIFO for decode.
// A flush discards buffered entries and turns live requests into drops.
// Optional: define FETCH_BYPASS_EN to forward a response straight to decode
// when the FIFO is empty (0-cycle response-to-decode latency).
module fetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int XLEN            = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            flush_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int TW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CNTW-1:0] count;

    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_rd, tag_wr;
    logic [OW-1:0]   live_cnt, drop_cnt;

    logic credit_ok, outstanding, rsp_drop, rsp_take, fifo_valid, bypass;
    logic push, pop;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Credit, handshakes, response routing and head/bypass output selection
    always_comb begin
        credit_ok = (32'(count) + 32'(live_cnt) < 32'(DEPTH)) &&
                    (32'(live_cnt) + 32'(drop_cnt) < 32'(MAX_OUTSTANDING));
        outstanding      = (live_cnt != '0) || (drop_cnt != '0);
        imem_req_valid_o = pc_valid_i && credit_ok && !flush_i && !reset;
        pc_ready_o       = imem_req_valid_o && imem_req_ready_i;
        imem_addr_o      = {pc_i[XLEN-1:2], 2'b00};

        rsp_drop   = imem_rsp_valid_i && (drop_cnt != '0);
        rsp_take   = imem_rsp_valid_i && (drop_cnt == '0) && (live_cnt != '0);
        fifo_valid = (count != '0);

        bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
        bypass = rsp_take && !fifo_valid && !flush_i;
`endif

        instr_valid_o = (fifo_valid || bypass) && !flush_i && !reset;
        instr_o       = '0;
        instr_pc_o    = '0;
        if (fifo_valid) begin
            instr_o    = ins_mem[rd_ptr];
            instr_pc_o = pc_mem[rd_ptr];
        end else if (bypass) begin
            instr_o    = imem_rsp_data_i;
            instr_pc_o = tag_mem[tag_rd];
        end

        pop  = instr_valid_o && instr_ready_i && fifo_valid;
        // A bypassed response consumed by decode never occupies a FIFO slot
        push = rsp_take && !flush_i && !reset && !(bypass && instr_ready_i);
    end

    // Entry storage for the FIFO and the PC tag queue (no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= tag_mem[tag_rd];
            ins_mem[wr_ptr] <= imem_rsp_data_i;
        end
        if (pc_ready_o) begin
            tag_mem[tag_wr] <= pc_i;
        end
    end

    // Pointers and counters; flush converts live requests into drops
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush_i) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            live_cnt <= '0;
            drop_cnt <= drop_cnt + live_cnt - OW'(imem_rsp_valid_i && outstanding);
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CNTW'(1);
            else if (pop && !push) count <= count - CNTW'(1);

            if (pc_ready_o) tag_wr <= tag_inc(tag_wr);
            if (rsp_take)   tag_rd <= tag_inc(tag_rd);
            if (pc_ready_o && !rsp_take)      live_cnt <= live_cnt + OW'(1);
            else if (!pc_ready_o && rsp_take) live_cnt <= live_cnt - OW'(1);

            if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is a protocol violation by imem
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid_i && !outstanding))
        else $error("fetch_buffer: imem response with no outstanding request");
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer. Accepted PCs push the
// expected {pc, instr} pair; a monitor pops and compares on every decode
// handshake. imem is modelled as an in-order responder with 1-cycle latency.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    fetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2), .XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_i             (pc_i),
        .pc_valid_i       (pc_valid_i),
        .pc_ready_o       (pc_ready_o),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .flush_i          (flush_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int base;

    logic [31:0] pcq[$];
    logic [63:0] exp_q[$];
    logic [31:0] pend[$];
    int          pop_cyc[$];
    bit          ifu_en = 1'b0;
    bit          took = 1'b0;
    bit          rsp_hold = 1'b0;

    // imem content: instruction word at a word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1300_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: record accepted PCs, forward fired requests to imem, score decode pops
    always @(negedge clk) begin
        if (!reset) begin
            if (flush_i) exp_q.delete();
            if (pc_ready_o) begin
                check("imem_addr", imem_addr_o, {pc_i[31:2], 2'b00});
                exp_q.push_back({pc_i, mem_word({pc_i[31:2], 2'b00})});
                took = 1'b1;
                acc_cnt++;
            end
            if (imem_req_valid_o && imem_req_ready_i) pend.push_back(imem_addr_o);
            if (instr_valid_o && instr_ready_i) begin
                logic [63:0] e;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc %0h instr %0h required none",
                             instr_pc_o, instr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc_o, e[63:32]);
                    check("instr", instr_o, e[31:0]);
                end
            end
        end
    end

    // ifu model: offer the head of pcq, advance when accepted
    always @(posedge clk) begin
        #2;
        if (took) begin
            void'(pcq.pop_front());
            took = 1'b0;
        end
        pc_valid_i = ifu_en && (pcq.size() > 0);
        pc_i       = (pcq.size() > 0) ? pcq[0] : 32'h0;
    end

    // imem responder: in-order, one cycle after the request, optionally held
    always @(posedge clk) begin
        #2;
        if (!rsp_hold && pend.size() > 0) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(pend.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = 32'h0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        while ((exp_q.size() != 0 || pcq.size() != 0) && budget > 0) begin
            tick(1);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush_i = 1'b0;
        instr_ready_i = 1'b1;
        imem_req_ready_i = 1'b1;
        pc_valid_i = 1'b0;
        pc_i = '0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = '0;
        tick(2);
        @(negedge clk);
        check("rst_instr_valid", instr_valid_o, 0);
        check("rst_pc_ready", pc_ready_o, 0);
        check("rst_req_valid", imem_req_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_instr_pc", instr_pc_o, 0);
        tick(1);
        reset = 1'b0;
        ifu_en = 1'b1;
        tick(1);

        // Streaming four PCs: consecutive pops once filled
        pop_cyc.delete();
        pcq = '{32'h0, 32'h4, 32'h8, 32'hC};
        wait_idle("stream", 40);
        check("stream_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() >= 4) check("stream_no_bubbles", pop_cyc[3] - pop_cyc[0], 3);
        tick(2);

        // Response-to-decode latency from an empty FIFO
        pcq = '{32'h20};
        begin
            int b = 20;
            @(negedge clk);
            while (!imem_rsp_valid_i && b > 0) begin
                @(negedge clk);
                b--;
            end
            check("rsp_seen", b > 0, 1);
`ifdef FETCH_BYPASS_EN
            check("bypass_valid", instr_valid_o, 1);
            check("bypass_pc", instr_pc_o, 32'h20);
            @(negedge clk);
            check("bypass_no_store", instr_valid_o, 0);
`else
            check("lat_same_cycle", instr_valid_o, 0);
            @(negedge clk);
            check("lat_one_cycle", instr_valid_o, 1);
`endif
        end
        tick(1);
        wait_idle("latency", 20);
        tick(2);

        // Backpressure: exactly DEPTH accepted, then drain and resume
        instr_ready_i = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) pcq.push_back(32'h1000 + 32'(4 * i));
        tick(15);
        @(negedge clk);
        check("bp_accepted", acc_cnt, 4);
        check("bp_pc_ready", pc_ready_o, 0);
        check("bp_instr_valid", instr_valid_o, 1);
        tick(1);
        instr_ready_i = 1'b1;
        wait_idle("bp_drain", 60);
        check("bp_resume", acc_cnt, 8);
        tick(2);

        // Misaligned PC: aligned address, PC passed through unmodified
        pcq = '{32'h302};
        wait_idle("misaligned", 20);
        tick(2);

        // Flush with two requests in flight; both responses dropped
        rsp_hold = 1'b1;
        base = acc_cnt;
        pcq = '{32'h500, 32'h504};
        tick(4);
        check("fl_inflight", acc_cnt - base, 2);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        rsp_hold = 1'b0;
        pcq.push_back(32'h100);
        @(negedge clk);
        check("fl_drop1_valid", instr_valid_o, 0);
        @(negedge clk);
        check("fl_drop2_valid", instr_valid_o, 0);
        tick(1);
        wait_idle("fl_new_pc", 30);
        tick(2);

        // Flush coincident with a response: one drop left afterwards
        rsp_hold = 1'b1;
        base = acc_cnt;
        pcq = '{32'h600, 32'h604};
        tick(4);
        check("flc_inflight", acc_cnt - base, 2);
        rsp_hold = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        check("flc_flush_valid", instr_valid_o, 0);
        tick(1);
        flush_i = 1'b0;
        pcq.push_back(32'h200);
        @(negedge clk);
        check("flc_drop_valid", instr_valid_o, 0);
        tick(1);
        wait_idle("flc_new_pc", 30);
        tick(2);

        // Back-to-back flushes accumulate drops
        rsp_hold = 1'b1;
        pcq = '{32'h700};
        tick(3);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        pcq = '{32'h704};
        tick(3);
        flush_i = 1'b1;
        tick(2);
        flush_i = 1'b0;
        pcq.push_back(32'h400);
        rsp_hold = 1'b0;
        wait_idle("fl_accum", 30);
        tick(2);

        // Reset mid-stream with three buffered entries
        instr_ready_i = 1'b0;
        pcq = '{32'h800, 32'h804, 32'h808};
        tick(8);
        @(negedge clk);
        check("rms_buffered", instr_valid_o, 1);
        tick(1);
        ifu_en = 1'b0;
        reset = 1'b1;
        pcq.delete();
        pend.delete();
        exp_q.delete();
        took = 1'b0;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("rms_instr_valid", instr_valid_o, 0);
        check("rms_pc_ready", pc_ready_o, 0);
        check("rms_instr", instr_o, 0);
        check("rms_instr_pc", instr_pc_o, 0);
        tick(1);
        ifu_en = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) pcq.push_back(32'h900 + 32'(4 * i));
        tick(15);
        check("rms_counters_clear", acc_cnt, 4);
        instr_ready_i = 1'b1;
        wait_idle("rms_drain", 40);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
